// File: rtl/mac_stream_feeder_if.sv
// -----------------------------------------------------------------------------
// mac_stream_feeder_if
// Bundle of every bus the feeder touches. The feeder uses the master modport:
// it drives the operand stream ready, the MAC controls and the result stream.
// The surrounding environment (operand buffer, MAC, result collector) uses the
// slave modport.
//   s_valid/s_ready/s_a/s_b/s_last   operand beat stream (signed operands)
//   mac_clear/mac_en/mac_a/mac_b     controls and operands to the MAC
//   mac_acc                          registered accumulator from the MAC
//   m_valid/m_ready/m_data/m_count/m_ovf  result stream
// -----------------------------------------------------------------------------
interface mac_stream_feeder_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int MAX_K  = 256
);
  localparam int CW = $clog2(MAX_K + 1);

  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_a;
  logic signed [DATA_W-1:0] s_b;
  logic                     s_last;

  logic                     mac_clear;
  logic                     mac_en;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic        [ACC_W-1:0]  mac_acc;

  logic                     m_valid;
  logic                     m_ready;
  logic        [ACC_W-1:0]  m_data;
  logic        [CW-1:0]     m_count;
  logic                     m_ovf;

  modport master (
    input  s_valid, s_a, s_b, s_last, mac_acc, m_ready,
    output s_ready, mac_clear, mac_en, mac_a, mac_b,
           m_valid, m_data, m_count, m_ovf
  );

  modport slave (
    output s_valid, s_a, s_b, s_last, mac_acc, m_ready,
    input  s_ready, mac_clear, mac_en, mac_a, mac_b,
           m_valid, m_data, m_count, m_ovf
  );
endinterface

// File: rtl/mac_stream_feeder.sv
// -----------------------------------------------------------------------------
// mac_stream_feeder
// Streaming front/back end for one accumulator MAC lane. Operand pairs arrive
// on a valid/ready stream terminated by a last flag; each accepted beat is
// forwarded to the MAC with mac_en. After the last beat the final accumulator
// is captured and offered on the result stream together with the beat count
// and an overflow flag (more than MAX_K beats in the vector).
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (returns to CLEAR, drops result)
//   bus  - mac_stream_feeder_if.master (operand, MAC and result buses)
//
// Build option:
//   MAC_FEEDER_ZERO_SKIP_EN - when defined, accepted beats with a zero operand
//   are counted and honour s_last but do not pulse mac_en (the product is zero,
//   so the accumulator value is unaffected and the MAC stays idle).
// -----------------------------------------------------------------------------
module mac_stream_feeder #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int MAX_K  = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_stream_feeder_if.master  bus
);

  localparam int CW = $clog2(MAX_K + 1);
  localparam logic [CW-1:0] MAX_K_C = CW'(MAX_K);

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OUT     = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [CW-1:0]       count_r;
  logic                ovf_r;
  logic [ACC_W-1:0]    m_data_r;
  logic [CW-1:0]       m_count_r;
  logic                m_ovf_r;

  logic                accept_s;
  logic                s_ready_s;
  logic                mac_clear_s;
  logic                mac_en_s;
  logic [DATA_W-1:0]   mac_a_s;
  logic [DATA_W-1:0]   mac_b_s;
  logic                load_result_s;

  // Decides whether an accepted beat has to be sent through the MAC.
  function automatic logic feed_mac(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
`ifdef MAC_FEEDER_ZERO_SKIP_EN
    feed_mac = (a != {DATA_W{1'b0}}) && (b != {DATA_W{1'b0}});
`else
    feed_mac = 1'b1;
`endif
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and MAC/stream control decode.
  always_comb begin
    state_next_s  = state_r;
    accept_s      = 1'b0;
    s_ready_s     = 1'b0;
    mac_clear_s   = 1'b0;
    mac_en_s      = 1'b0;
    mac_a_s       = {DATA_W{1'b0}};
    mac_b_s       = {DATA_W{1'b0}};
    load_result_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        mac_clear_s  = 1'b1;
        state_next_s = ST_ACCUM;
      end
      ST_ACCUM: begin
        s_ready_s = 1'b1;
        if (bus.s_valid) begin
          // Operands only reach the MAC on an accepted beat; zero otherwise.
          accept_s = 1'b1;
          mac_a_s  = bus.s_a;
          mac_b_s  = bus.s_b;
          mac_en_s = feed_mac(bus.s_a, bus.s_b);
          if (bus.s_last) begin
            state_next_s = ST_CAPTURE;
          end else begin
            state_next_s = ST_ACCUM;
          end
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_CAPTURE: begin
        // mac_acc is registered in the MAC, so it includes the last product now.
        load_result_s = 1'b1;
        state_next_s  = ST_OUT;
      end
      ST_OUT: begin
        if (bus.m_ready) begin
          state_next_s = ST_CLEAR;
        end else begin
          state_next_s = ST_OUT;
        end
      end
      default: begin
        state_next_s = ST_CLEAR;
      end
    endcase
  end

  // Beat counter (saturating at MAX_K) and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
      ovf_r   <= 1'b0;
    end else if (state_r == ST_CLEAR) begin
      count_r <= {CW{1'b0}};
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      if (count_r == MAX_K_C) begin
        ovf_r <= 1'b1;
      end else begin
        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      count_r <= count_r;
    end
  end

  // Result holding registers, loaded once per vector in CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_r  <= {ACC_W{1'b0}};
      m_count_r <= {CW{1'b0}};
      m_ovf_r   <= 1'b0;
    end else if (load_result_s) begin
      m_data_r  <= bus.mac_acc;
      m_count_r <= count_r;
      m_ovf_r   <= ovf_r;
    end else begin
      m_data_r  <= m_data_r;
      m_count_r <= m_count_r;
      m_ovf_r   <= m_ovf_r;
    end
  end

  assign bus.s_ready   = s_ready_s;
  assign bus.mac_clear = mac_clear_s;
  assign bus.mac_en    = mac_en_s;
  assign bus.mac_a     = mac_a_s;
  assign bus.mac_b     = mac_b_s;
  // Decoded straight from the state register so reset drops it asynchronously.
  assign bus.m_valid   = (state_r == ST_OUT);
  assign bus.m_data    = m_data_r;
  assign bus.m_count   = m_count_r;
  assign bus.m_ovf     = m_ovf_r;

endmodule

// File: tb/tb_mac_stream_feeder.sv
// -----------------------------------------------------------------------------
// tb_mac_stream_feeder
// Drives directed and randomized operand vectors into mac_stream_feeder, with a
// behavioural MAC attached, and compares each result against the dot product,
// beat count and overflow flag computed from the vector contents.
// -----------------------------------------------------------------------------
module tb_mac_stream_feeder;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int MAX_K  = 4;
  localparam int CW     = $clog2(MAX_K + 1);

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   va[$];
  int   vb[$];
  logic signed [ACC_W-1:0] acc_r;

  mac_stream_feeder_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_K(MAX_K)) bus ();

  mac_stream_feeder #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_K(MAX_K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: registered accumulator with synchronous clear.
  always @(posedge clk) begin
    if (bus.mac_clear) begin
      acc_r <= '0;
    end else if (bus.mac_en) begin
      acc_r <= acc_r + (ACC_W'(bus.mac_a) * ACC_W'(bus.mac_b));
    end
  end
  assign bus.mac_acc = acc_r;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Sends va/vb as one vector, checks the MAC drive per beat and the result.
  // abort_in_out asserts rst while the result is pending instead of taking it.
  task automatic run_vector(input int gap_pct, input int bp_cycles, input bit abort_in_out);
    int n = va.size();
    int idx = 0;
    int cyc = 0;
    longint sum = 0;
    logic [ACC_W-1:0] exp_data;
    logic [DATA_W-1:0] exp_a;
    logic [DATA_W-1:0] got_a;
    logic exp_en;
    logic accepted;
    for (int i = 0; i < n; i++) sum += longint'(va[i] * vb[i]);
    exp_data = sum[ACC_W-1:0];
    while (idx < n && cyc < 200) begin
      bus.s_valid = ($urandom_range(99) >= gap_pct);
      bus.s_a     = DATA_W'(va[idx]);
      bus.s_b     = DATA_W'(vb[idx]);
      bus.s_last  = (idx == n - 1);
      #1;
      if (bus.s_ready) begin
`ifdef MAC_FEEDER_ZERO_SKIP_EN
        exp_en = bus.s_valid && (va[idx] != 0) && (vb[idx] != 0);
`else
        exp_en = bus.s_valid;
`endif
        chk("mac_en_beat", 64'(bus.mac_en), 64'(exp_en));
        if (bus.s_valid) begin
          exp_a = DATA_W'(va[idx]);
          got_a = bus.mac_a;
          chk("mac_a", 64'(got_a), 64'(exp_a));
        end
      end else begin
        chk("mac_en_not_ready", 64'(bus.mac_en), 64'd0);
      end
      chk("clear_en_excl", 64'(bus.mac_en & bus.mac_clear), 64'd0);
      accepted = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (accepted) idx++;
      cyc++;
    end
    chk("beat_timeout", 64'(idx), 64'(n));
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    // One cycle after the last beat: capturing, no result yet.
    chk("m_valid_capture", 64'(bus.m_valid), 64'd0);
    chk("s_ready_capture", 64'(bus.s_ready), 64'd0);
    @(posedge clk); #1;
    chk("m_valid_2cyc", 64'(bus.m_valid), 64'd1);
    chk("m_data", 64'(bus.m_data), 64'(exp_data));
    chk("m_count", 64'(bus.m_count), 64'((n > MAX_K) ? MAX_K : n));
    chk("m_ovf", 64'(bus.m_ovf), 64'(n > MAX_K));
    if (abort_in_out) begin
      rst = 1'b1;
      #1;
      chk("rst_m_valid_async", 64'(bus.m_valid), 64'd0);
      chk("rst_m_data", 64'(bus.m_data), 64'd0);
      chk("rst_mac_clear", 64'(bus.mac_clear), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("s_ready_after_rst", 64'(bus.s_ready), 64'd1);
    end else begin
      for (int c = 0; c < bp_cycles; c++) begin
        @(posedge clk); #1;
        chk("bp_m_valid", 64'(bus.m_valid), 64'd1);
        chk("bp_m_data", 64'(bus.m_data), 64'(exp_data));
        chk("bp_s_ready", 64'(bus.s_ready), 64'd0);
        chk("bp_mac_en", 64'(bus.mac_en), 64'd0);
      end
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      chk("post_hs_m_valid", 64'(bus.m_valid), 64'd0);
      chk("post_hs_s_ready", 64'(bus.s_ready), 64'd0);
      chk("post_hs_mac_clear", 64'(bus.mac_clear), 64'd1);
      @(posedge clk); #1;
      chk("post_hs_s_ready2", 64'(bus.s_ready), 64'd1);
      chk("accum_mac_clear", 64'(bus.mac_clear), 64'd0);
    end
  endtask

  task automatic load_vec(input int a0, input int b0, input int len);
    va.delete();
    vb.delete();
    for (int i = 0; i < len; i++) begin
      va.push_back(a0);
      vb.push_back(b0);
    end
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_a      = '0;
    bus.s_b      = '0;
    bus.s_last   = 1'b0;
    bus.m_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_mac_clear", 64'(bus.mac_clear), 64'd1);
    chk("rst_mac_en", 64'(bus.mac_en), 64'd0);
    chk("rst_mac_a", 64'(unsigned'(bus.mac_a)), 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_data", 64'(bus.m_data), 64'd0);
    chk("rst_m_count", 64'(bus.m_count), 64'd0);
    chk("rst_m_ovf", 64'(bus.m_ovf), 64'd0);
    rst = 1'b0;
    chk("cyc0_mac_clear", 64'(bus.mac_clear), 64'd1);
    @(posedge clk); #1;
    chk("cyc1_s_ready", 64'(bus.s_ready), 64'd1);

    // Basic three-beat vector: 4 - 10 + 18 = 12.
    va = '{1, 2, 3}; vb = '{4, -5, 6};
    run_vector(0, 0, 1'b0);
    // Extreme one-beat vector followed by one that proves the MAC was cleared.
    va = '{-128}; vb = '{-128};
    run_vector(0, 0, 1'b0);
    va = '{127}; vb = '{1};
    run_vector(0, 0, 1'b0);
    // Result backpressure for 10 cycles.
    va = '{1, 2, 3}; vb = '{4, -5, 6};
    run_vector(0, 10, 1'b0);
    // Overflow: six beats against MAX_K = 4.
    load_vec(1, 1, 6);
    run_vector(0, 0, 1'b0);
    // Zero operands still count toward m_count.
    va = '{0, 5}; vb = '{7, 2};
    run_vector(0, 0, 1'b0);

    // Reset after two accepted beats of a vector.
    bus.s_valid = 1'b1; bus.s_a = 8'sd3; bus.s_b = 8'sd3; bus.s_last = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midvec_rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("midvec_rst_mac_clear", 64'(bus.mac_clear), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midvec_s_ready", 64'(bus.s_ready), 64'd1);
    va = '{2}; vb = '{2};
    run_vector(0, 0, 1'b0);

    // Reset while a result is pending, then a fresh vector.
    va = '{9, -9}; vb = '{9, 9};
    run_vector(0, 2, 1'b1);
    va = '{-3, 4}; vb = '{5, 6};
    run_vector(0, 0, 1'b0);

    // Randomized vectors with stream gaps, zeros and backpressure.
    for (int v = 0; v < 30; v++) begin
      int len;
      len = int'($urandom_range(1, 7));
      va.delete();
      vb.delete();
      for (int i = 0; i < len; i++) begin
        va.push_back(($urandom_range(7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128);
        vb.push_back(($urandom_range(7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128);
      end
      run_vector(25, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mac_stream_feeder.md
# mac_stream_feeder

Streaming front/back end for a single accumulator MAC: accepts signed operand pairs over a valid/ready stream with a last flag and drives the MAC's clear/enable/operand inputs. After each vector it captures the final accumulator and presents it on an output valid/ready stream. One feeder sits beside each MAC lane of the matrix accelerator, between the operand buffers and the result collector.

## Interface
- DATA_W, 8, operand width (signed two's complement)
- ACC_W, 32, accumulator/result width
- MAX_K, 256, maximum beats per vector; beat counter width CW = $clog2(MAX_K+1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  operand beat valid
- s_ready  out  1  feeder can accept beat
- s_a  in  DATA_W  signed operand A
- s_b  in  DATA_W  signed operand B
- s_last  in  1  final beat of current vector
- mac_clear  out  1  synchronous clear to MAC accumulator
- mac_en  out  1  MAC accumulate enable
- mac_a  out  DATA_W  operand A to MAC
- mac_b  out  DATA_W  operand B to MAC
- mac_acc  in  ACC_W  MAC accumulator value (registered in MAC)
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_data  out  ACC_W  captured dot-product result
- m_count  out  CW  beats accepted in this vector
- m_ovf  out  1  vector exceeded MAX_K beats

## Operation
- FSM states: CLEAR, ACCUM, CAPTURE, OUT. Reset state CLEAR.
- CLEAR: mac_clear=1, s_ready=0, beat counter and ovf flag zeroed; next cycle -> ACCUM.
- ACCUM: s_ready=1. Beat accepted when s_valid & s_ready. mac_a=s_a, mac_b=s_b combinationally; mac_en = accepted beat (Moore-gated by state, Mealy on s_valid). Counter increments per accepted beat, saturating at MAX_K; accepting a beat while counter==MAX_K sets ovf (sticky until CLEAR). Accepted beat with s_last=1 -> CAPTURE.
- CAPTURE: s_ready=0, mac_en=0; mac_acc now includes the last product; m_data<=mac_acc, m_count<=counter, m_ovf<=ovf; -> OUT.
- OUT: m_valid=1, m_data/m_count/m_ovf held stable; on m_valid & m_ready -> CLEAR.
- mac_en is only ever high in ACCUM; mac_clear only in CLEAR; never both.
- A vector of one beat (s_last on first beat) is legal: result = s_a*s_b.
- Arithmetic is performed by the MAC; the feeder does no widening or saturation of data.

## Timing
- Reset values: s_ready=0, mac_clear=1 (CLEAR is reset state), mac_en=0, mac_a=mac_b=0 when no beat, m_valid=0, m_data=0, m_count=0, m_ovf=0.
- After rst deasserts: cycle 0 CLEAR, cycle 1 ACCUM with s_ready=1.
- Last beat accepted at edge N -> CAPTURE during cycle N..N+1 -> m_valid=1 from edge N+2. Latency last-beat-to-result: 2 cycles.
- After result handshake at edge M: CLEAR in cycle M..M+1, s_ready=1 from edge M+2. Vector-to-vector gap: 2 cycles of s_ready=0 plus OUT dwell.
- m_ready backpressure holds OUT indefinitely; s_ready stays 0.
- s_valid low in ACCUM: no mac_en, counter unchanged, state unchanged.
- rst asserted mid-vector or in OUT: immediate return to CLEAR, pending result discarded, m_valid drops asynchronously; MAC cleared by mac_clear in first post-reset cycle.

## Configuration
- MAC_FEEDER_ZERO_SKIP_EN defined: an accepted beat with s_a==0 or s_b==0 counts toward m_count and honours s_last but leaves mac_en=0 (power saving); m_data unchanged in value.
- Undefined: every accepted beat asserts mac_en.

## Test plan
- Single vector A={1,2,3}, B={4,-5,6}, last on beat 3, m_ready=1 -> m_data=12, m_count=3, m_ovf=0, m_valid exactly 2 cycles after last beat.
- One-beat vector A=-128, B=-128 -> m_data=16384, m_count=1; then A=127,B=1 next vector -> m_data=127 (proves clear between vectors).
- Backpressure: m_ready=0 for 10 cycles after result -> m_valid/m_data stable, s_ready=0, mac_en=0 throughout; release -> s_ready=1 two cycles later.
- MAX_K=4, send 6 beats of (1,1) with last on 6th -> m_count=4, m_ovf=1, m_data=6.
- Assert rst for 1 cycle after 2 beats of (3,3), then send vector (2,2) last -> m_data=4, m_count=1.
- With MAC_FEEDER_ZERO_SKIP_EN: A={0,5}, B={7,2} -> mac_en low on beat 1, high on beat 2; m_data=10, m_count=2.
